// File: rtl/tx_interrupt_sequencer.sv
// Tx interrupt sequencer: edge-detects eight tx event sources into per-line pending bits and
// raises two acknowledged interrupt pulses with cause/overflow. Optional post-ack holdoff: TX_INTR_HOLDOFF_EN.
module tx_interrupt_sequencer #(
  parameter int HOLDOFF_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               src_evt,
  input  logic [7:0]               src_mask0,
  input  logic [7:0]               src_mask1,
  input  logic [3:0]               pulse_len,
  input  logic [HOLDOFF_WIDTH-1:0] holdoff,
  input  logic                     ack0,
  input  logic                     ack1,
  output logic                     tx_itrpt0,
  output logic                     tx_itrpt1,
  output logic [7:0]               cause0,
  output logic [7:0]               cause1,
  output logic                     ovf0,
  output logic                     ovf1
);

`ifdef TX_INTR_HOLDOFF_EN
  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_WAIT_ACK, S_HOLDOFF} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_WAIT_ACK} state_t;
  logic unused_holdoff;
  assign unused_holdoff = ^holdoff;
`endif

  logic [7:0] src_evt_p0;
  logic [7:0] rise;

  // stage p0: previous-sample register for rising-edge detection
  always_ff @(posedge clk) begin
    if (rst) src_evt_p0 <= '0;
    else     src_evt_p0 <= src_evt;
  end

  assign rise = src_evt & ~src_evt_p0;

  logic [7:0] mask_l  [2];
  logic       ack_l   [2];
  logic       itrpt_l [2];
  logic [7:0] cause_l [2];
  logic       ovf_l   [2];

  assign mask_l[0] = src_mask0;
  assign mask_l[1] = src_mask1;
  assign ack_l[0]  = ack0;
  assign ack_l[1]  = ack1;

  assign tx_itrpt0 = itrpt_l[0];
  assign tx_itrpt1 = itrpt_l[1];
  assign cause0    = cause_l[0];
  assign cause1    = cause_l[1];
  assign ovf0      = ovf_l[0];
  assign ovf1      = ovf_l[1];

  for (genvar l = 0; l < 2; l++) begin : g_line
    state_t     state_q, state_d;
    logic [7:0] pending_q, pending_d;
    logic [7:0] cause_q, cause_d;
    logic [7:0] grant, clr;
    logic [3:0] pcnt_q, pcnt_d;
    logic       itrpt_q;
    logic       ovf_q, ovf_d;
    logic       blk_q, blk_d;
`ifdef TX_INTR_HOLDOFF_EN
    logic [HOLDOFF_WIDTH-1:0] hcnt_q, hcnt_d;
`endif

    assign grant = pending_q & mask_l[l];

    // blk holds off capture for the single idle cycle that directly follows an accepted ack,
    // so the next pulse lands no earlier than two edges after the ack.
    always_comb begin
      state_d = state_q;
      pcnt_d  = pcnt_q;
      cause_d = cause_q;
      ovf_d   = ovf_q;
      blk_d   = 1'b0;
      clr     = '0;
`ifdef TX_INTR_HOLDOFF_EN
      hcnt_d  = hcnt_q;
`endif
      case (state_q)
        S_IDLE: begin
          if ((grant != '0) && !blk_q) begin
            cause_d = grant;
            clr     = grant;
            pcnt_d  = pulse_len;
            state_d = S_PULSE;
          end
        end
        S_PULSE: begin
          if (pcnt_q == '0) state_d = S_WAIT_ACK;
          else              pcnt_d  = pcnt_q - 4'd1;
        end
        S_WAIT_ACK: begin
          if (ack_l[l]) begin
            cause_d = '0;
            ovf_d   = 1'b0;
            blk_d   = 1'b1;
`ifdef TX_INTR_HOLDOFF_EN
            if (holdoff != '0) begin
              hcnt_d  = holdoff;
              state_d = S_HOLDOFF;
            end else begin
              state_d = S_IDLE;
            end
`else
            state_d = S_IDLE;
`endif
          end
        end
`ifdef TX_INTR_HOLDOFF_EN
        S_HOLDOFF: begin
          if (hcnt_q == '0) state_d = S_IDLE;
          else              hcnt_d  = hcnt_q - HOLDOFF_WIDTH'(1);
        end
`endif
        default: state_d = S_IDLE;
      endcase
      // a new edge on an already-pending source is flagged; the set also wins over capture-clear
      if ((rise & pending_q) != '0) ovf_d = 1'b1;
      pending_d = (pending_q & ~clr) | rise;
    end

    // stage p1: line state, pending, cause and registered interrupt output
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q   <= S_IDLE;
        pending_q <= '0;
        cause_q   <= '0;
        pcnt_q    <= '0;
        itrpt_q   <= 1'b0;
        ovf_q     <= 1'b0;
        blk_q     <= 1'b0;
`ifdef TX_INTR_HOLDOFF_EN
        hcnt_q    <= '0;
`endif
      end else begin
        state_q   <= state_d;
        pending_q <= pending_d;
        cause_q   <= cause_d;
        pcnt_q    <= pcnt_d;
        itrpt_q   <= (state_d == S_PULSE);
        ovf_q     <= ovf_d;
        blk_q     <= blk_d;
`ifdef TX_INTR_HOLDOFF_EN
        hcnt_q    <= hcnt_d;
`endif
      end
    end

    assign itrpt_l[l] = itrpt_q;
    assign cause_l[l] = cause_q;
    assign ovf_l[l]   = ovf_q;
  end

endmodule

// File: tb/tb_tx_interrupt_sequencer.sv
// Self-checking bench for tx_interrupt_sequencer: table of single-event vectors with a
// scoreboard queue, plus hand-written multi-cycle sequences (holdoff, overflow, collision, mask, reset).
module tb_tx_interrupt_sequencer;
  localparam int HW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    src_evt, src_mask0, src_mask1;
  logic [3:0]    pulse_len;
  logic [HW-1:0] holdoff;
  logic          ack0, ack1;
  logic          tx_itrpt0, tx_itrpt1;
  logic [7:0]    cause0, cause1;
  logic          ovf0, ovf1;

  int total = 0;
  int bad   = 0;

  tx_interrupt_sequencer #(.HOLDOFF_WIDTH(HW)) dut (
    .clk(clk), .rst(rst), .src_evt(src_evt), .src_mask0(src_mask0), .src_mask1(src_mask1),
    .pulse_len(pulse_len), .holdoff(holdoff), .ack0(ack0), .ack1(ack1),
    .tx_itrpt0(tx_itrpt0), .tx_itrpt1(tx_itrpt1), .cause0(cause0), .cause1(cause1),
    .ovf0(ovf0), .ovf1(ovf1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] evt;
    logic [7:0] m0;
    logic [7:0] m1;
    logic [3:0] plen;
    logic [7:0] c0;
    logic [7:0] c1;
  } vec_t;

  typedef struct {
    logic [7:0] c0;
    logic [7:0] c1;
    int         w0;
    int         w1;
  } exp_t;

  exp_t sb[$];
  vec_t vt[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    src_evt = '0; ack0 = 1'b0; ack1 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_itrpt0", tx_itrpt0, 0);
    chk("rst_itrpt1", tx_itrpt1, 0);
    chk("rst_cause0", cause0, 0);
    chk("rst_cause1", cause1, 0);
    chk("rst_ovf0", ovf0, 0);
    chk("rst_ovf1", ovf1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [7:0] c0s, c1s;
    logic f0, f1;
    int w0, w1, n;

    vt[0] = '{8'h02, 8'h02, 8'h00, 4'd2,  8'h02, 8'h00};
    vt[1] = '{8'h18, 8'hFF, 8'h00, 4'd0,  8'h18, 8'h00};
    vt[2] = '{8'h20, 8'h20, 8'h20, 4'd1,  8'h20, 8'h20};
    vt[3] = '{8'h41, 8'h01, 8'h40, 4'd3,  8'h01, 8'h40};
    vt[4] = '{8'h80, 8'h0F, 8'hF0, 4'd15, 8'h00, 8'h80};

    rst = 1'b1; src_evt = '0; src_mask0 = '0; src_mask1 = '0;
    pulse_len = '0; holdoff = '0; ack0 = 1'b0; ack1 = 1'b0;

    for (int i = 0; i < 5; i++) begin
      do_reset();
      src_mask0 = vt[i].m0; src_mask1 = vt[i].m1; pulse_len = vt[i].plen; holdoff = '0;
      src_evt = vt[i].evt;
      e.c0 = vt[i].c0; e.c1 = vt[i].c1;
      e.w0 = (vt[i].c0 != 0) ? int'(vt[i].plen) + 1 : 0;
      e.w1 = (vt[i].c1 != 0) ? int'(vt[i].plen) + 1 : 0;
      sb.push_back(e);
      tick();
      src_evt = '0;
      chk($sformatf("v%0d_lat0", i), tx_itrpt0, 0);
      chk($sformatf("v%0d_lat1", i), tx_itrpt1, 0);
      tick();
      c0s = cause0; c1s = cause1; f0 = tx_itrpt0; f1 = tx_itrpt1;
      w0 = 0; w1 = 0;
      for (int c = 0; c < 20; c++) begin
        if (tx_itrpt0) w0++;
        if (tx_itrpt1) w1++;
        tick();
      end
      e = sb.pop_front();
      chk($sformatf("v%0d_first0", i), f0, e.w0 != 0);
      chk($sformatf("v%0d_first1", i), f1, e.w1 != 0);
      chk($sformatf("v%0d_cause0", i), c0s, e.c0);
      chk($sformatf("v%0d_cause1", i), c1s, e.c1);
      chk($sformatf("v%0d_width0", i), w0, e.w0);
      chk($sformatf("v%0d_width1", i), w1, e.w1);
      chk($sformatf("v%0d_hold0", i), cause0, e.c0);
      chk($sformatf("v%0d_hold1", i), cause1, e.c1);
      chk($sformatf("v%0d_ovf0", i), ovf0, 0);
      ack0 = (e.c0 != 0); ack1 = (e.c1 != 0);
      tick();
      ack0 = 1'b0; ack1 = 1'b0;
      chk($sformatf("v%0d_ackc0", i), cause0, 0);
      chk($sformatf("v%0d_ackc1", i), cause1, 0);
    end

    // pending during WAIT_ACK, ack ignored during PULSE, holdoff timing
    do_reset();
    src_mask0 = 8'h03; src_mask1 = '0; pulse_len = 4'd3; holdoff = 16'd5;
    src_evt = 8'h02;
    tick();
    src_evt = '0;
    tick();
    chk("a_start", tx_itrpt0, 1);
    chk("a_cause", cause0, 8'h02);
    n = 1;
    ack0 = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      ack0 = 1'b0;
      if (tx_itrpt0) n++;
    end
    chk("a_width", n, 4);
    chk("a_cause_kept", cause0, 8'h02);
    src_evt = 8'h01;
    tick();
    src_evt = '0;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (tx_itrpt0) n++;
    end
    chk("a_no_pulse_before_ack", n, 0);
    ack0 = 1'b1;
    tick();
    ack0 = 1'b0;
    chk("a_ack_cause", cause0, 0);
    n = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (tx_itrpt0 && n == 0) n = c;
    end
`ifdef TX_INTR_HOLDOFF_EN
    chk("a_next_delay", n, 7);
`else
    chk("a_next_delay", n, 2);
`endif
    chk("a_next_cause", cause0, 8'h01);

    // overflow: double rise on bit2 before capture
    do_reset();
    src_mask0 = '0; src_mask1 = '0; pulse_len = 4'd0; holdoff = '0;
    src_evt = 8'h04; tick(); src_evt = '0; tick();
    chk("b_ovf_single", ovf0, 0);
    src_evt = 8'h04; tick(); src_evt = '0; tick();
    chk("b_ovf_set", ovf0, 1);
    chk("b_masked_quiet", tx_itrpt0, 0);
    src_mask0 = 8'h04;
    tick();
    chk("b_pulse", tx_itrpt0, 1);
    chk("b_cause", cause0, 8'h04);
    chk("b_ovf_kept", ovf0, 1);
    tick();
    chk("b_pulse_end", tx_itrpt0, 0);
    ack0 = 1'b1; tick(); ack0 = 1'b0;
    chk("b_ack_ovf", ovf0, 0);
    chk("b_ack_cause", cause0, 0);

    // collision: rise on bit2 in the capture cycle stays pending
    do_reset();
    src_mask0 = '0; pulse_len = 4'd1; holdoff = '0;
    src_evt = 8'h04; tick(); src_evt = '0; tick();
    src_mask0 = 8'h04; src_evt = 8'h04;
    tick();
    src_evt = '0;
    chk("c_pulse", tx_itrpt0, 1);
    chk("c_cause", cause0, 8'h04);
    tick();
    chk("c_pulse2", tx_itrpt0, 1);
    tick();
    chk("c_pulse_end", tx_itrpt0, 0);
    ack0 = 1'b1; tick(); ack0 = 1'b0;
    n = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (tx_itrpt0 && n == 0) n = c;
    end
    chk("c_second_delay", n, 2);
    chk("c_second_cause", cause0, 8'h04);

    // masked bit7 accumulates, fires once unmasked
    do_reset();
    src_mask0 = '0; src_mask1 = '0; pulse_len = 4'd0;
    src_evt = 8'h80; tick(); src_evt = '0;
    n = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (tx_itrpt0 || tx_itrpt1) n++;
    end
    chk("d_masked_quiet", n, 0);
    src_mask0 = 8'h80;
    tick();
    chk("d_pulse", tx_itrpt0, 1);
    chk("d_cause", cause0, 8'h80);
    chk("d_line1_quiet", tx_itrpt1, 0);

    // reset in the middle of a pulse
    do_reset();
    src_mask0 = '0; pulse_len = 4'd5;
    src_evt = 8'h01; tick(); src_evt = '0; tick();
    src_evt = 8'h01; tick(); src_evt = '0;
    src_mask0 = 8'h01;
    tick();
    chk("e_pulse", tx_itrpt0, 1);
    chk("e_ovf", ovf0, 1);
    rst = 1'b1;
    tick();
    chk("e_rst_itrpt", tx_itrpt0, 0);
    chk("e_rst_cause", cause0, 0);
    chk("e_rst_ovf", ovf0, 0);
    rst = 1'b0;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (tx_itrpt0) n++;
    end
    chk("e_no_pulse_after_rst", n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
